// File: rtl/mem_read_sequencer.sv
// Read-side sequencer for the 1K x 16 on-chip memory: issues rd_en bursts with
// 0-3 wait states per word and streams the captured words out through a small FIFO.
module mem_read_sequencer #(
  parameter int DATA_W     = 16,
  parameter int LEN_W      = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        wait_states,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic              mem_multi_cycle_mode,
  output logic [1:0]        mem_cycle_count,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, issued_q;
  logic [1:0]         w_q, phase_q;
  logic               abort_q;
  logic               vld_p1, last_p1;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];
  logic               fifo_last [FIFO_DEPTH];

  logic               abort_eff, credit_ok, word_end, last_word, push, pop;
  logic [CNT_W:0]     occupancy;

  assign abort_eff = abort | abort_q;
  // Slots already promised: words in the FIFO plus the one the memory just captured.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, vld_p1};
  assign credit_ok = occupancy < DEPTH_C;
  assign word_end  = mem_rd_en && (phase_q == w_q);
  assign last_word = (issued_q + LEN_W'(1)) == len_q;

  always_comb begin
    state_d   = state_q;
    mem_rd_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (len == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        // Once a word has started it always runs its full W+1 cycles.
        if (phase_q != 2'd0)              mem_rd_en = 1'b1;
        else if (!abort_eff && credit_ok) mem_rd_en = 1'b1;
        if (word_end && (last_word || abort_eff)) state_d = S_DRAIN;
        else if (phase_q == 2'd0 && abort_eff)    state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!vld_p1 && count_q == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy                 = (state_q != S_IDLE);
  assign done                 = (state_q == S_DONE);
  assign mem_multi_cycle_mode = busy && (w_q != 2'd0);
  assign mem_cycle_count      = busy ? w_q : 2'd0;

  // Stage p0 -> p1: issue side; vld_p1 marks a word the memory captured on this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      w_q      <= '0;
      issued_q <= '0;
      phase_q  <= '0;
      abort_q  <= 1'b0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        len_q    <= len;
        w_q      <= wait_states;
        issued_q <= '0;
        phase_q  <= '0;
        abort_q  <= 1'b0;
      end
      if (mem_rd_en) phase_q <= word_end ? 2'd0 : phase_q + 2'd1;
      if (word_end)  issued_q <= issued_q + LEN_W'(1);
      vld_p1  <= word_end;
      last_p1 <= word_end && last_word;
      if (state_q == S_READ && abort) abort_q <= 1'b1;
      else if (state_q == S_DONE)     abort_q <= 1'b0;
    end
  end

  // Stage p1 -> FIFO: registered memory data is valid one cycle after capture.
  assign push    = vld_p1 && !abort_q;
  assign m_valid = (count_q != '0) && !abort_q;
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? fifo_data[rd_ptr_q] : '0;
  assign m_last  = m_valid && fifo_last[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (abort_q) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_q] <= mem_data_out;
      fifo_last[wr_ptr_q] <= last_p1;
    end
  end

endmodule

// File: tb/tb_mem_read_sequencer.sv
// Bench for mem_read_sequencer: behavioural memory model, negedge monitor,
// table of whole-transfer vectors plus hand-written timing/reset sequences.
module tb_mem_read_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [10:0] len = '0;
  logic [1:0]  wait_states = '0;
  logic        abort = 1'b0;
  logic        busy, done, mem_rd_en, mem_multi_cycle_mode;
  logic [1:0]  mem_cycle_count;
  logic [15:0] mem_data_out;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        m_last;

  mem_read_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .wait_states(wait_states), .abort(abort), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_multi_cycle_mode(mem_multi_cycle_mode),
    .mem_cycle_count(mem_cycle_count), .mem_data_out(mem_data_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input int a);
    return 16'h5A00 + 16'(a * 3);
  endfunction

  // Memory model: captures on the (W+1)th consecutive rd_en edge, auto-increments address.
  int       maddr;
  int       mwait;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      maddr = 0; mwait = 0; mem_data_out <= '0;
    end else if (mem_rd_en) begin
      if (mwait == int'(mem_cycle_count)) begin
        mem_data_out <= mem_word(maddr);
        maddr = maddr + 1;
        mwait = 0;
      end else mwait = mwait + 1;
    end
  end

  // Monitor (sole writer of its counters); an epoch change from test_id clears them.
  int          cyc = 0, stall_until = 0, test_id = 0, seen_id = -1, cur_w = 0;
  int          got_n, rd_cnt, run_cur, run_max, rd_stalled, last_cnt, done_cnt, mode_err, stab_err;
  logic [15:0] got_d [64];
  logic        got_l [64];
  int          got_c [64];
  logic        prev_v, prev_r, prev_l;
  logic [15:0] prev_d;

  always @(negedge clk) begin
    cyc++;
    m_ready = (cyc > stall_until);
    if (seen_id != test_id) begin
      seen_id = test_id;
      got_n = 0; rd_cnt = 0; run_cur = 0; run_max = 0; rd_stalled = 0;
      last_cnt = 0; done_cnt = 0; mode_err = 0; stab_err = 0;
      prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_d = '0;
    end
    if (mem_rd_en) begin
      rd_cnt++; run_cur++;
      if (run_cur > run_max) run_max = run_cur;
      if (!m_ready) rd_stalled++;
    end else run_cur = 0;
    if (done) done_cnt++;
    if (busy) begin
      if (mem_multi_cycle_mode != (cur_w != 0) || int'(mem_cycle_count) != cur_w) mode_err++;
    end else if (mem_multi_cycle_mode || mem_cycle_count != 2'd0) mode_err++;
    if (prev_v && !prev_r && busy && (!m_valid || m_data != prev_d || m_last != prev_l)) stab_err++;
    if (m_valid && m_ready && got_n < 64) begin
      got_d[got_n] = m_data; got_l[got_n] = m_last; got_c[got_n] = cyc;
      got_n++;
      if (m_last) last_cnt++;
    end
    prev_v = m_valid; prev_r = m_ready; prev_d = m_data; prev_l = m_last;
  end

  int errors = 0, checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_mode"}, mem_multi_cycle_mode, 0);
    chk({tag, "_cc"}, mem_cycle_count, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_last"}, m_last, 0);
  endtask

  task automatic do_reset();
    start = 0; abort = 0; len = '0; wait_states = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic begin_xfer(input int l, input int w, input int stall);
    test_id++;
    cur_w = w;
    stall_until = cyc + stall;
    len = 11'(l); wait_states = 2'(w); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 3000; k++) begin
      if (done_cnt != 0) break;
      @(posedge clk);
    end
    #1;
    chk({tag, "_done_seen"}, (done_cnt != 0), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int len; int w; int stall; int abort_at;
    int exp_words; int exp_rd; int exp_run; int exp_stall_rd; int exp_last;
  } vec_t;
  vec_t vecs [5];

  initial begin
    vecs[0] = '{4, 0, 0,  -1, 4, 4,  4,  0, 1};
    vecs[1] = '{3, 2, 0,  -1, 3, 9,  9,  0, 1};
    vecs[2] = '{8, 0, 10, -1, 8, 8,  -1, 4, 1};
    vecs[3] = '{6, 3, 0,  9,  2, 12, 12, 0, 0};
    vecs[4] = '{0, 1, 0,  -1, 0, 0,  0,  0, 0};

    #1 reset_n = 1'b0;
    #1 chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // First-word latency with W=0.
    begin_xfer(4, 0, 0);
    chk("lat_rd_en_E0", mem_rd_en, 1);
    chk("lat_busy_E0", busy, 1);
    chk("lat_valid_E0", m_valid, 0);
    @(posedge clk); #1;
    chk("lat_valid_E1", m_valid, 0);
    @(posedge clk); #1;
    chk("lat_valid_E2", m_valid, 1);
    chk("lat_data_E2", m_data, mem_word(0));
    wait_done("lat");

    // abort while idle is ignored.
    abort = 1'b1; @(posedge clk); #1 abort = 1'b0;
    chk("idle_abort_busy", busy, 0);

    // len=0: done the cycle after start, then idle.
    do_reset();
    begin_xfer(0, 0, 0);
    chk("len0_done", done, 1);
    chk("len0_rd_en", mem_rd_en, 0);
    @(posedge clk); #1;
    chk("len0_done_next", done, 0);
    chk("len0_busy_next", busy, 0);

    for (int i = 0; i < 5; i++) begin
      string t;
      int n;
      t = $sformatf("v%0d", i);
      do_reset();
      begin_xfer(vecs[i].len, vecs[i].w, vecs[i].stall);
      if (vecs[i].abort_at >= 0) begin
        repeat (vecs[i].abort_at) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
      end
      wait_done(t);
      chk({t, "_words"}, got_n, vecs[i].exp_words);
      chk({t, "_rd_cycles"}, rd_cnt, vecs[i].exp_rd);
      if (vecs[i].exp_run >= 0) chk({t, "_rd_run"}, run_max, vecs[i].exp_run);
      chk({t, "_rd_while_stalled"}, rd_stalled, vecs[i].exp_stall_rd);
      chk({t, "_last_count"}, last_cnt, vecs[i].exp_last);
      chk({t, "_done_pulses"}, done_cnt, 1);
      chk({t, "_mode_errs"}, mode_err, 0);
      chk({t, "_stable_errs"}, stab_err, 0);
      chk({t, "_busy_after"}, busy, 0);
      n = (got_n < vecs[i].exp_words) ? got_n : vecs[i].exp_words;
      for (int k = 0; k < n; k++) begin
        chk($sformatf("%s_data%0d", t, k), got_d[k], mem_word(k));
        chk($sformatf("%s_last%0d", t, k), got_l[k],
            (vecs[i].exp_last != 0 && k == vecs[i].len - 1));
        if (k > 0 && vecs[i].stall == 0 && vecs[i].abort_at < 0)
          chk($sformatf("%s_gap%0d", t, k), got_c[k] - got_c[k-1], vecs[i].w + 1);
      end
    end

    // Asynchronous reset mid-transfer, then a clean follow-up transfer.
    do_reset();
    begin_xfer(5, 1, 0);
    for (int k = 0; k < 200; k++) begin
      if (got_n >= 2) break;
      @(posedge clk);
    end
    chk("rst_mid_two_words", (got_n >= 2), 1);
    @(negedge clk); #2 reset_n = 1'b0;
    #1 chk_outputs_zero("rst_mid");
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    begin_xfer(2, 0, 0);
    wait_done("post_rst");
    chk("post_rst_words", got_n, 2);
    chk("post_rst_data0", got_d[0], mem_word(0));
    chk("post_rst_data1", got_d[1], mem_word(1));
    chk("post_rst_last1", got_l[1], 1);
    chk("post_rst_done", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
